// File: rtl/count_accumulator.sv
// Windowed accumulator of 0..4 set-bit counts with valid/ready handshake on both sides.
// Optional macro COUNT_ACC_SATURATE_EN: saturate the total on overflow instead of wrapping.
module count_accumulator #(
   parameter int WINDOW  = 4,
   parameter int TOTAL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               switch,
   input  logic               clear,
   input  logic               in_valid,
   input  logic [2:0]         count,
   output logic               in_ready,
   input  logic               out_ready,
   output logic               out_valid,
   output logic [TOTAL_W-1:0] total,
   output logic               ovf,
   output logic               err
);

   typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

   localparam logic [TOTAL_W-1:0] TOTAL_MAX  = '1;
   localparam logic [7:0]         WINDOW_CNT = 8'(WINDOW);

   state_t               state_reg;
   logic [7:0]           sample_cnt_reg;
   logic [TOTAL_W-1:0]   total_reg;
   logic                 ovf_reg;
   logic                 err_reg;
   logic                 out_valid_reg;

   logic                 accept;
   logic                 count_bad;
   logic [2:0]           count_clamped;
   logic [TOTAL_W-1:0]   base;
   logic [TOTAL_W:0]     sum_next;
   logic                 carry;
   logic [TOTAL_W-1:0]   total_add;
   logic [7:0]           cnt_inc;

   assign in_ready      = switch && !reset && (state_reg != DONE);
   assign accept        = in_valid && in_ready;
   assign count_bad     = (count > 3'd4);
   assign count_clamped = count_bad ? 3'd4 : count;
   assign base          = (state_reg == IDLE) ? '0 : total_reg;
   assign sum_next      = {1'b0, base} + (TOTAL_W+1)'(count_clamped);
   assign carry         = sum_next[TOTAL_W];
   assign cnt_inc       = sample_cnt_reg + 8'd1;

`ifdef COUNT_ACC_SATURATE_EN
   // Once a window has overflowed it stays pinned at the maximum until it ends.
   assign total_add = (carry || (ovf_reg && state_reg == ACCUM)) ? TOTAL_MAX : sum_next[TOTAL_W-1:0];
`else
   assign total_add = sum_next[TOTAL_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_reg      <= IDLE;
         sample_cnt_reg <= '0;
         total_reg      <= '0;
         ovf_reg        <= 1'b0;
         err_reg        <= 1'b0;
         out_valid_reg  <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  total_reg      <= total_add;
                  sample_cnt_reg <= 8'd1;
                  ovf_reg        <= carry;
                  err_reg        <= count_bad;
                  if (WINDOW_CNT == 8'd1) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                  end else begin
                     state_reg <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (accept) begin
                  total_reg      <= total_add;
                  sample_cnt_reg <= cnt_inc;
                  ovf_reg        <= ovf_reg | carry;
                  err_reg        <= err_reg | count_bad;
                  if (cnt_inc == WINDOW_CNT) begin
                     state_reg     <= DONE;
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            DONE: begin
               // Handshake completes even with switch low.
               if (out_ready) begin
                  state_reg      <= IDLE;
                  sample_cnt_reg <= '0;
                  total_reg      <= '0;
                  ovf_reg        <= 1'b0;
                  err_reg        <= 1'b0;
                  out_valid_reg  <= 1'b0;
               end
            end
            default: begin
               state_reg     <= IDLE;
               out_valid_reg <= 1'b0;
            end
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign total     = total_reg;
   assign ovf       = ovf_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_count_accumulator.sv
// Directed bench for count_accumulator: WINDOW=4 instance plus a WINDOW=80 instance for overflow.
module tb_count_accumulator;

   logic       clk = 1'b0;
   logic       reset, switch, clear, in_valid, out_ready;
   logic [2:0] count;
   logic       in_ready, out_valid, ovf, err;
   logic [7:0] total;
   logic       in_ready_b, out_valid_b, ovf_b, err_b;
   logic [7:0] total_b;

   int total_cnt = 0;
   int bad_cnt   = 0;

   always #5 clk = ~clk;

   count_accumulator #(.WINDOW(4), .TOTAL_W(8)) dut (
      .clk(clk), .reset(reset), .switch(switch), .clear(clear),
      .in_valid(in_valid), .count(count), .in_ready(in_ready),
      .out_ready(out_ready), .out_valid(out_valid), .total(total),
      .ovf(ovf), .err(err)
   );

   count_accumulator #(.WINDOW(80), .TOTAL_W(8)) dut_b (
      .clk(clk), .reset(reset), .switch(switch), .clear(clear),
      .in_valid(in_valid), .count(count), .in_ready(in_ready_b),
      .out_ready(out_ready), .out_valid(out_valid_b), .total(total_b),
      .ovf(ovf_b), .err(err_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [2:0] c);
      in_valid = 1'b1;
      count    = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; switch = 1'b1; clear = 1'b0; in_valid = 1'b1; count = 3'd4; out_ready = 1'b0;
      tick(); tick();
      total_cnt++;
      if ({out_valid, total, ovf, err, in_ready} !== 12'h000) begin
         bad_cnt++;
         $display("FAIL reset_state: got ov=%0b tot=%0d ovf=%0b err=%0b rdy=%0b, want all 0", out_valid, total, ovf, err, in_ready);
      end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      total_cnt++;
      if (in_ready !== 1'b1) begin
         bad_cnt++;
         $display("FAIL reset_release_ready: got %0b want 1", in_ready);
      end
      $display("test_reset done");
   endtask

   task automatic test_basic();
      feed(3'd1); feed(3'd2); feed(3'd3);
      total_cnt++;
      if (out_valid !== 1'b0 || total !== 8'd6) begin
         bad_cnt++;
         $display("FAIL basic_partial: got ov=%0b tot=%0d want ov=0 tot=6", out_valid, total);
      end
      feed(3'd4);
      total_cnt++;
      if (out_valid !== 1'b1 || total !== 8'd10 || ovf !== 1'b0 || err !== 1'b0 || in_ready !== 1'b0) begin
         bad_cnt++;
         $display("FAIL basic_done: got ov=%0b tot=%0d ovf=%0b err=%0b rdy=%0b want 1/10/0/0/0", out_valid, total, ovf, err, in_ready);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || total !== 8'd0 || in_ready !== 1'b1) begin
         bad_cnt++;
         $display("FAIL basic_handshake: got ov=%0b tot=%0d rdy=%0b want 0/0/1", out_valid, total, in_ready);
      end
      $display("test_basic window 1,2,3,4 total=%0d", 10);
   endtask

   task automatic test_backpressure();
      feed(3'd1); feed(3'd2); feed(3'd3); feed(3'd4);
      in_valid = 1'b1; count = 3'd4;
      for (int i = 0; i < 3; i++) begin
         tick();
         total_cnt++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || total !== 8'd10) begin
            bad_cnt++;
            $display("FAIL backpressure_hold%0d: got rdy=%0b ov=%0b tot=%0d want 0/1/10", i, in_ready, out_valid, total);
         end
      end
      in_valid = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || total !== 8'd0) begin
         bad_cnt++;
         $display("FAIL backpressure_release: got ov=%0b tot=%0d want 0/0", out_valid, total);
      end
      $display("test_backpressure held 3 cycles");
   endtask

   task automatic test_err();
      feed(3'd1); feed(3'd5);
      total_cnt++;
      if (err !== 1'b1 || total !== 8'd5) begin
         bad_cnt++;
         $display("FAIL err_set: got err=%0b tot=%0d want 1/5", err, total);
      end
      feed(3'd0); feed(3'd2);
      total_cnt++;
      if (out_valid !== 1'b1 || total !== 8'd7 || err !== 1'b1 || ovf !== 1'b0) begin
         bad_cnt++;
         $display("FAIL err_window: got ov=%0b tot=%0d err=%0b ovf=%0b want 1/7/1/0", out_valid, total, err, ovf);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      total_cnt++;
      if (err !== 1'b0) begin
         bad_cnt++;
         $display("FAIL err_cleared: got %0b want 0", err);
      end
      $display("test_err window 1,5,0,2 total=%0d", 7);
   endtask

   task automatic test_clear();
      feed(3'd3); feed(3'd3);
      clear = 1'b1; in_valid = 1'b1; count = 3'd3; tick();
      clear = 1'b0; in_valid = 1'b0;
      total_cnt++;
      if (total !== 8'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad_cnt++;
         $display("FAIL clear_mid: got tot=%0d ov=%0b rdy=%0b want 0/0/1", total, out_valid, in_ready);
      end
      feed(3'd1); feed(3'd1); feed(3'd1);
      total_cnt++;
      if (out_valid !== 1'b0) begin
         bad_cnt++;
         $display("FAIL clear_restart_count: got ov=%0b want 0", out_valid);
      end
      feed(3'd1);
      total_cnt++;
      if (out_valid !== 1'b1 || total !== 8'd4) begin
         bad_cnt++;
         $display("FAIL clear_new_window: got ov=%0b tot=%0d want 1/4", out_valid, total);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      $display("test_clear new window total=%0d", 4);
   endtask

   task automatic test_freeze();
      feed(3'd2);
      switch = 1'b0; in_valid = 1'b1; count = 3'd4;
      tick(); tick();
      total_cnt++;
      if (in_ready !== 1'b0 || total !== 8'd2 || out_valid !== 1'b0) begin
         bad_cnt++;
         $display("FAIL freeze_hold: got rdy=%0b tot=%0d ov=%0b want 0/2/0", in_ready, total, out_valid);
      end
      switch = 1'b1; in_valid = 1'b0;
      feed(3'd2); feed(3'd2); feed(3'd2);
      total_cnt++;
      if (out_valid !== 1'b1 || total !== 8'd8) begin
         bad_cnt++;
         $display("FAIL freeze_resume: got ov=%0b tot=%0d want 1/8", out_valid, total);
      end
      switch = 1'b0; out_ready = 1'b1; tick(); out_ready = 1'b0; switch = 1'b1;
      total_cnt++;
      if (out_valid !== 1'b0 || total !== 8'd0) begin
         bad_cnt++;
         $display("FAIL freeze_done_handshake: got ov=%0b tot=%0d want 0/0", out_valid, total);
      end
      $display("test_freeze total=%0d", 8);
   endtask

   task automatic test_reset_mid();
      feed(3'd4); feed(3'd4); feed(3'd4); feed(3'd4);
      reset = 1'b1; tick(); reset = 1'b0;
      total_cnt++;
      if ({out_valid, total, ovf, err} !== 11'h000) begin
         bad_cnt++;
         $display("FAIL reset_in_done: got ov=%0b tot=%0d ovf=%0b err=%0b want all 0", out_valid, total, ovf, err);
      end
      feed(3'd3); feed(3'd5);
      switch = 1'b0; reset = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) begin
         bad_cnt++;
         $display("FAIL ready_during_reset: got %0b want 0", in_ready);
      end
      switch = 1'b1;
      #1;
      total_cnt++;
      if (in_ready !== 1'b0) begin
         bad_cnt++;
         $display("FAIL ready_during_reset_sw1: got %0b want 0", in_ready);
      end
      switch = 1'b0;
      tick(); reset = 1'b0;
      total_cnt++;
      if ({out_valid, total, ovf, err} !== 11'h000) begin
         bad_cnt++;
         $display("FAIL reset_mid_accum: got ov=%0b tot=%0d ovf=%0b err=%0b want all 0", out_valid, total, ovf, err);
      end
      switch = 1'b1;
      feed(3'd1); feed(3'd1); feed(3'd1); feed(3'd1);
      total_cnt++;
      if (out_valid !== 1'b1 || total !== 8'd4 || err !== 1'b0) begin
         bad_cnt++;
         $display("FAIL reset_fresh_window: got ov=%0b tot=%0d err=%0b want 1/4/0", out_valid, total, err);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      $display("test_reset_mid done");
   endtask

   task automatic test_overflow();
      logic [7:0] exp64, exp80;
`ifdef COUNT_ACC_SATURATE_EN
      exp64 = 8'd255; exp80 = 8'd255;
`else
      exp64 = 8'd0;   exp80 = 8'd64;
`endif
      reset = 1'b1; tick(); reset = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1; count = 3'd4;
      for (int i = 1; i <= 80; i++) begin
         tick();
         if (i == 63) begin
            total_cnt++;
            if (total_b !== 8'd252 || ovf_b !== 1'b0) begin
               bad_cnt++;
               $display("FAIL ovf_before: got tot=%0d ovf=%0b want 252/0", total_b, ovf_b);
            end
         end
         if (i == 64) begin
            total_cnt++;
            if (total_b !== exp64 || ovf_b !== 1'b1) begin
               bad_cnt++;
               $display("FAIL ovf_edge: got tot=%0d ovf=%0b want %0d/1", total_b, ovf_b, exp64);
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      total_cnt++;
      if (out_valid_b !== 1'b1 || total_b !== exp80 || ovf_b !== 1'b1 || err_b !== 1'b0) begin
         bad_cnt++;
         $display("FAIL ovf_final: got ov=%0b tot=%0d ovf=%0b err=%0b want 1/%0d/1/0", out_valid_b, total_b, ovf_b, err_b, exp80);
      end
      out_ready = 1'b1; tick(); out_ready = 1'b0;
      total_cnt++;
      if (out_valid_b !== 1'b0 || ovf_b !== 1'b0 || total_b !== 8'd0) begin
         bad_cnt++;
         $display("FAIL ovf_handshake: got ov=%0b ovf=%0b tot=%0d want 0/0/0", out_valid_b, ovf_b, total_b);
      end
      $display("test_overflow window of 80 x 4 total=%0d", exp80);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_err();
      test_clear();
      test_freeze();
      test_reset_mid();
      test_overflow();
      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule

// File: doc/count_accumulator.md
COUNT_ACCUMULATOR -- requirements
Module: count_accumulator

Interface
REQ-001 Parameter WINDOW, default 4: number of accepted samples per result (legal range 1..255).
REQ-002 Parameter TOTAL_W, default 8: width of the accumulated total.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 switch  input  1  enable; when 0, no sample is accepted and state is held.
REQ-006 clear  input  1  synchronous restart of the current window.
REQ-007 in_valid  input  1  count is presented this cycle.
REQ-008 count  input  3  set-bit count from the upstream 4-input counting stage (legal 0..4).
REQ-009 in_ready  output  1  block accepts a sample this cycle.
REQ-010 out_ready  input  1  consumer takes the result this cycle.
REQ-011 out_valid  output  1  total holds a finished window result.
REQ-012 total  output  TOTAL_W  running or finished sum of accepted counts.
REQ-013 ovf  output  1  sticky: the window sum exceeded 2^TOTAL_W-1.
REQ-014 err  output  1  sticky: an accepted count was greater than 4.

Function
REQ-015 The block SHALL implement states IDLE, ACCUM and DONE.
REQ-016 in_ready SHALL be 1 in IDLE and ACCUM when switch=1, and 0 in DONE or when switch=0.
REQ-017 A sample SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-018 Any accepted count>4 SHALL be treated as 4, and err SHALL be set to 1.
REQ-019 IDLE, accept: total<=count, sample counter<=1, next state ACCUM, or DONE if WINDOW=1.
REQ-020 ACCUM, accept: total<=total+count and sample counter increments.
REQ-021 ACCUM, accept of sample number WINDOW: next state DONE.
REQ-022 Latency: out_valid SHALL be 1 in the cycle directly after the edge that accepts the last sample.
REQ-023 DONE: out_valid=1; total, ovf and err held stable until out_ready=1.
REQ-024 DONE with out_ready=1 at an edge: next state IDLE; total, sample counter, ovf and err cleared to 0.
REQ-025 Cycles with in_valid=1 while in_ready=0 SHALL be ignored, with no effect on any state.
REQ-026 switch=0 SHALL freeze ACCUM; DONE still completes its handshake on out_ready.
REQ-027 clear=1 at an edge SHALL force IDLE and zero total, sample counter, ovf and err, overriding any accept or handshake in the same cycle.
REQ-028 Addition SHALL be performed at TOTAL_W+1 bits; a carry out SHALL set ovf.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, with total=0, out_valid=0, ovf=0, err=0 and sample counter=0; reset has priority over clear and all other inputs.
REQ-030 Reset asserted in mid-window or in DONE SHALL discard the partial or pending result, with no out_valid pulse.
REQ-031 in_ready SHALL be 0 in any cycle where reset=1.

Configuration
REQ-032 Macro COUNT_ACC_SATURATE_EN defined: on overflow, total SHALL saturate at 2^TOTAL_W-1 and stay there for the rest of the window; ovf is set.
REQ-033 Macro COUNT_ACC_SATURATE_EN undefined: total SHALL wrap modulo 2^TOTAL_W; ovf is still set.

Verification
REQ-034 WINDOW=4, switch=1, counts 1,2,3,4 accepted on consecutive cycles -> out_valid=1 the next cycle with total=10, ovf=0, err=0; out_ready=1 -> IDLE with total=0.
REQ-035 Result pending with out_ready=0 for 3 cycles while in_valid=1, count=4 -> in_ready=0, total stays 10, samples ignored; out_ready=1 -> IDLE.
REQ-036 WINDOW=80, TOTAL_W=8, count=4 every cycle -> with macro: total=255, ovf=1; without macro: total=64 (320 mod 256), ovf=1.
REQ-037 count=5 accepted in a window of 1,5,0,2 -> total=7 (5 treated as 4), err=1.
REQ-038 clear after 2 samples (counts 3,3) -> IDLE with total=0; a new window of counts 1,1,1,1 -> total=4.
REQ-039 reset asserted in DONE, and separately with switch=0 in mid-ACCUM -> all outputs 0 on the next cycle and state IDLE.
